// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the load extraction/extension helper.
package dmem_responder_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

    // Right-align the addressed byte/half, then sign- or zero-extend.
    function automatic logic [31:0] loadExtend(input logic [2:0]  funct3,
                                               input logic [1:0]  offset,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (funct3)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LW:      result = word;
            LBU:     result = {24'h0, shifted[7:0]};
            LHU:     result = {16'h0, shifted[15:0]};
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load
// extraction/extension, and detection of misaligned or unsupported accesses.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataLane,
    output logic [31:0] loadData,
    output logic        accErr
);

    always_comb begin
        accErr    = 1'b0;
        byteEn    = 4'b0000;
        wdataLane = wdata;
        if (we) begin
            case (funct3)
                SB: begin
                    byteEn    = 4'b0001 << offset;
                    wdataLane = {4{wdata[7:0]}};
                end
                SH: begin
                    accErr    = offset[0];
                    byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                    wdataLane = {2{wdata[15:0]}};
                end
                SW: begin
                    accErr = |offset;
                    byteEn = 4'b1111;
                end
                default: accErr = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB, LBU:  accErr = 1'b0;
                LH, LHU:  accErr = offset[0];
                LW:       accErr = |offset;
                default:  accErr = 1'b1;
            endcase
        end
        // A faulting store must not touch any lane.
        if (accErr) byteEn = 4'b0000;
    end

    assign loadData = (accErr || we) ? 32'h0 : loadExtend(funct3, offset, rword);

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stall FSM with countdown, word RAM
// with byte-enable writes, and a sticky access-error flag.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_funct3,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    stateT       state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] wordIdx;
    logic [31:0]   rword, wdataLane, loadData;
    logic [3:0]    byteEn;
    logic          accErr, complete, memWrite;
    logic          unusedAddrBits;

    assign wordIdx        = cpu_addr[AW+1:2];
    assign unusedAddrBits = ^cpu_addr[31:AW+2];
    assign rword          = mem[wordIdx];

    dmem_lane_align uAlign (
        .we       (cpu_we),
        .funct3   (cpu_funct3),
        .offset   (cpu_addr[1:0]),
        .wdata    (cpu_wdata),
        .rword    (rword),
        .byteEn   (byteEn),
        .wdataLane(wdataLane),
        .loadData (loadData),
        .accErr   (accErr)
    );

    // With zero latency the access completes in the IDLE request cycle itself.
    assign complete = rst && cpu_req &&
                      ((LATENCY == 0) ? (state == IDLE) : (state == DONE));
    assign memWrite = complete && cpu_we && !accErr;

    assign cpu_stall = rst && (((state == IDLE) && cpu_req && (LATENCY != 0)) ||
                               (state == WAIT));
    assign cpu_rdata = complete ? loadData : 32'h0;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (LATENCY == 1) begin
                        stateNext = DONE;
                    end else if (LATENCY >= 2) begin
                        stateNext = WAIT;
                        cntNext   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!cpu_req) begin
                    stateNext = IDLE;
                    cntNext   = 4'd0;
                end else if (cnt == 4'd0) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mem_err <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            mem_err <= mem_err || (complete && accErr);
        end
    end

    // RAM is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (memWrite && byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataLane[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 0, 2 and 3 sharing one
// stimulus bus; a byte-array reference model predicts every completion.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic        we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [2:0]  stall, err;
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .cpu_req(req[0]), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_funct3(f3), .cpu_rdata(rdata[0]),
        .cpu_stall(stall[0]), .mem_err(err[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .cpu_req(req[1]), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_funct3(f3), .cpu_rdata(rdata[1]),
        .cpu_stall(stall[1]), .mem_err(err[1]));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .cpu_req(req[2]), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_funct3(f3), .cpu_rdata(rdata[2]),
        .cpu_stall(stall[2]), .mem_err(err[2]));

    int lat[3] = '{0, 2, 3};
    int errors = 0;
    int checks = 0;

    typedef struct {int sel; logic [31:0] rd;} expT;
    expT expQ[$];
    expT mx;

    logic [7:0] mb [3][4096];
    bit         errSticky[3];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory as 4 KiB of bytes (address modulo 4*1024), access size
    // and signedness from funct3, misalignment as address modulo size.
    function automatic void model(input int s, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] fn,
                                  output logic [31:0] rd, output bit e);
        int     size, base;
        bit     sgn, bad;
        longint v;
        size = 1; sgn = 0; bad = 0;
        case (fn)
            3'd0:    begin size = 1; sgn = 1; end
            3'd1:    begin size = 2; sgn = 1; end
            3'd2:    size = 4;
            3'd4:    begin size = 1; bad = w; end
            3'd5:    begin size = 2; bad = w; end
            default: bad = 1;
        endcase
        e    = bad || ((int'(a[1:0]) % size) != 0);
        base = int'(a[11:0]);
        rd   = 32'h0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[s][base + i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v | (longint'(mb[s][base + i]) << (8*i));
                if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic access(int s, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] fn);
        logic [31:0] rd;
        bit          e;
        int          nStall, cyc;
        model(s, w, a, d, fn, rd, e);
        if (e) errSticky[s] = 1'b1;
        expQ.push_back('{s, rd});
        we = w; addr = a; wdata = d; f3 = fn;
        req = 3'b000; req[s] = 1'b1;
        nStall = 0; cyc = 0;
        do begin
            @(negedge clk);
            if (stall[s]) nStall++;
            cyc++;
        end while (stall[s] && cyc < 40);
        check("stallCount", nStall, lat[s]);
        @(posedge clk); #1;
        check("memErr", {31'h0, err[s]}, {31'h0, errSticky[s]});
    endtask

    // Monitor: a completion is any cycle with request held and no stall.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int s = 0; s < 3; s++) begin
                if (req[s] && !stall[s]) begin
                    if (expQ.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboardEmpty actual=completion@dut%0d required=none", s);
                    end else begin
                        mx = expQ.pop_front();
                        check("completionSel", s, mx.sel);
                        check("rdata", rdata[s], mx.rd);
                    end
                end else begin
                    check("rdataIdle", rdata[s], 32'h0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          s;
        bit          w;
        logic [2:0]  fn;
        logic [2:0]  validFn [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1; req = 3'b000; we = 1'b0; addr = '0; wdata = '0; f3 = '0;
        #2 rst = 1'b0; req = 3'b111;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("rstStall", {31'h0, stall[i]}, 32'h0);
            check("rstRdata", rdata[i], 32'h0);
            check("rstErr", {31'h0, err[i]}, 32'h0);
        end
        req = 3'b000;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Directed, LATENCY=2
        access(1, 1, 32'h10, 32'hDEADBEEF, 3'd2);
        access(1, 0, 32'h10, 32'h0, 3'd2);
        access(1, 1, 32'h13, 32'h80, 3'd0);
        access(1, 0, 32'h13, 32'h0, 3'd0);
        access(1, 0, 32'h13, 32'h0, 3'd4);
        access(1, 0, 32'h10, 32'h0, 3'd2);
        access(1, 0, 32'h1010, 32'h0, 3'd2);
        access(1, 1, 32'h1020, 32'h11112222, 3'd2);
        access(1, 0, 32'h11, 32'h0, 3'd1);
        access(1, 1, 32'h11, 32'hFFFF, 3'd1);
        access(1, 0, 32'h10, 32'h0, 3'd2);

        // Reset during WAIT of a store
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; f3 = 3'd2; req = 3'b010;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("stallAfterRst", {31'h0, stall[1]}, 32'h0);
        check("errAfterRst", {31'h0, err[1]}, 32'h0);
        req = 3'b000;
        errSticky = '{default: 1'b0};
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 32'h20, 32'h0, 3'd2);

        // LATENCY=0 back-to-back
        access(0, 1, 32'h40, 32'h0000ABCD, 3'd2);
        access(0, 0, 32'h40, 32'h0, 3'd2);

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++) access(d, 1, 32'(i * 4), $urandom, 3'd2);

        // Request withdrawn mid-WAIT (LATENCY=3): store must not commit
        we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; f3 = 3'd2; req = 3'b100;
        @(posedge clk); #1 req = 3'b000;
        @(posedge clk); #1;
        check("stallAfterAbort", {31'h0, stall[2]}, 32'h0);
        access(2, 0, 32'h30, 32'h0, 3'd2);

        repeat (300) begin
            s  = $urandom_range(0, 2);
            w  = 1'($urandom_range(0, 1));
            fn = validFn[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) fn = 3'($urandom_range(0, 7));
            r = $urandom;
            access(s, w, {r[31:12], 4'h0, r[7:0]}, $urandom, fn);
        end

        req = 3'b000;
        repeat (3) @(posedge clk);
        #1 check("queueDrained", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
